// File: rtl/fifo_packet_combiner.sv
// fifo_packet_combiner
// Merges WIDTH first-word-fall-through input FIFOs into a single output FIFO.
// Each output word is tagged with its source channel and start/end-of-packet
// flags. In packet mode a grant stays on one channel until that channel's
// end-of-packet word, so packets from different sources never interleave.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | arbitrate every cycle across all non-empty channels
// LOCKED | grant held on lock_ch until its r_last word is popped
module fifo_packet_combiner #(
  parameter int    WIDTH        = 4,
  parameter int    WIDTH_W      = $clog2(WIDTH),
  parameter int    DATA_W       = 32,
  parameter string ENCODER_MODE = "ROUND_ROBIN",
  parameter string PKT_MODE     = "TRUE",
  parameter string OUT_REG      = "FALSE"
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [WIDTH-1:0]          r_empty,
  output logic [WIDTH-1:0]          r_req,
  input  logic [WIDTH*DATA_W-1:0]   r_data,
  input  logic [WIDTH-1:0]          r_last,
  input  logic                      w_full,
  output logic                      w_req,
  output logic [DATA_W-1:0]         w_data,
  output logic                      w_last,
  output logic                      w_sop,
  output logic [WIDTH_W-1:0]        w_id,
  output logic                      busy
);

  localparam bit IS_PRIO = (ENCODER_MODE == "PRIORITY");
  localparam bit IS_PKT  = (PKT_MODE == "TRUE");
  localparam bit IS_OREG = (OUT_REG == "TRUE");

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]         state, state_nxt;
  logic [WIDTH_W-1:0] lock_ch, lock_ch_nxt;
  logic [WIDTH_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [WIDTH-1:0]   elig;
  logic [WIDTH_W-1:0] grant;
  logic               found;
  logic               pop;
  logic [DATA_W-1:0]  sel_data;

  logic               c_req;
  logic [DATA_W-1:0]  c_data;
  logic               c_last;
  logic               c_sop;
  logic [WIDTH_W-1:0] c_id;

  // Eligible channels: every non-empty one, or only the locked one mid-packet.
  always_comb begin
    elig = ~r_empty;
    if (state == ST_LOCKED) begin
      elig = '0;
      elig[lock_ch] = ~r_empty[lock_ch];
    end
  end

  // Pick one eligible channel; descending scan so the first hit in search order wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (IS_PRIO) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (elig[i]) begin
          grant = WIDTH_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      // Search starts just above rr_ptr and wraps modulo WIDTH, so the index
      // stays below WIDTH even when WIDTH is not a power of two.
      for (int i = WIDTH; i >= 1; i--) begin
        if (elig[(int'(rr_ptr) + i) % WIDTH]) begin
          grant = WIDTH_W'((int'(rr_ptr) + i) % WIDTH);
          found = 1'b1;
        end
      end
    end
  end

  assign pop = nrst & found & ~w_full;

  // Read strobe and data mux for the granted channel.
  always_comb begin
    r_req    = '0;
    sel_data = r_data[grant*DATA_W +: DATA_W];
    if (pop) r_req[grant] = 1'b1;
  end

  // Unregistered view of the output word; zero whenever nothing is popped.
  always_comb begin
    c_req  = pop;
    c_data = pop ? sel_data : '0;
    c_last = pop & r_last[grant];
    c_sop  = pop & (state == ST_IDLE);
    c_id   = pop ? grant : '0;
  end

  // Next-state: IDLE pops update the round-robin pointer and may take a lock.
  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    rr_ptr_nxt  = rr_ptr;
    if (pop) begin
      if (state == ST_IDLE) begin
        rr_ptr_nxt = grant;
        if (IS_PKT && !r_last[grant]) begin
          state_nxt   = ST_LOCKED;
          lock_ch_nxt = grant;
        end
      end else if (r_last[grant]) begin
        state_nxt = ST_IDLE;
      end
    end
  end

  // busy reflects the lock as it stands after this cycle's pop, so it is
  // high on every word of a packet except the last one.
  assign busy = nrst & (state_nxt == ST_LOCKED);

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= ST_IDLE;
      lock_ch <= '0;
      rr_ptr  <= WIDTH_W'(WIDTH - 1);
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  generate
    if (IS_OREG) begin : g_oreg
      // Registered output word, one cycle after the matching r_req.
      always_ff @(posedge clk) begin
        if (!nrst) begin
          w_req  <= 1'b0;
          w_data <= '0;
          w_last <= 1'b0;
          w_sop  <= 1'b0;
          w_id   <= '0;
        end else begin
          w_req  <= c_req;
          w_data <= c_data;
          w_last <= c_last;
          w_sop  <= c_sop;
          w_id   <= c_id;
        end
      end
    end else begin : g_comb
      assign w_req  = c_req;
      assign w_data = c_data;
      assign w_last = c_last;
      assign w_sop  = c_sop;
      assign w_id   = c_id;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_packet_combiner.sv
// Bench for fifo_packet_combiner. Four instances cover the configurations:
//   0: round robin, packet mode, combinational outputs
//   1: priority, word mode
//   2: round robin, word mode
//   3: round robin, packet mode, registered outputs
// Per-channel source queues model the FWFT input FIFOs; expected output
// words are queued as stimulus is loaded and consumed by a negedge monitor.
module tb_fifo_packet_combiner;

  localparam int NI = 4;

  logic         clk = 1'b0;
  logic         nrst;
  logic [3:0]   r_empty [NI];
  logic [3:0]   r_req   [NI];
  logic [127:0] r_data  [NI];
  logic [3:0]   r_last  [NI];
  logic         w_full  [NI];
  logic         w_req   [NI];
  logic [31:0]  w_data  [NI];
  logic         w_last  [NI];
  logic         w_sop   [NI];
  logic [1:0]   w_id    [NI];
  logic         busy    [NI];

  logic [32:0]  src_q [NI][4][$];
  logic [35:0]  exp_q [NI][$];
  logic [3:0]   hold  [NI];
  logic [3:0]   pop_mask [NI];
  logic [35:0]  sb_e;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_packet_combiner #(.WIDTH(4), .DATA_W(32), .ENCODER_MODE("ROUND_ROBIN"),
    .PKT_MODE("TRUE"), .OUT_REG("FALSE")) u_rr_pkt (
    .clk(clk), .nrst(nrst), .r_empty(r_empty[0]), .r_req(r_req[0]), .r_data(r_data[0]),
    .r_last(r_last[0]), .w_full(w_full[0]), .w_req(w_req[0]), .w_data(w_data[0]),
    .w_last(w_last[0]), .w_sop(w_sop[0]), .w_id(w_id[0]), .busy(busy[0]));

  fifo_packet_combiner #(.WIDTH(4), .DATA_W(32), .ENCODER_MODE("PRIORITY"),
    .PKT_MODE("FALSE"), .OUT_REG("FALSE")) u_pri_word (
    .clk(clk), .nrst(nrst), .r_empty(r_empty[1]), .r_req(r_req[1]), .r_data(r_data[1]),
    .r_last(r_last[1]), .w_full(w_full[1]), .w_req(w_req[1]), .w_data(w_data[1]),
    .w_last(w_last[1]), .w_sop(w_sop[1]), .w_id(w_id[1]), .busy(busy[1]));

  fifo_packet_combiner #(.WIDTH(4), .DATA_W(32), .ENCODER_MODE("ROUND_ROBIN"),
    .PKT_MODE("FALSE"), .OUT_REG("FALSE")) u_rr_word (
    .clk(clk), .nrst(nrst), .r_empty(r_empty[2]), .r_req(r_req[2]), .r_data(r_data[2]),
    .r_last(r_last[2]), .w_full(w_full[2]), .w_req(w_req[2]), .w_data(w_data[2]),
    .w_last(w_last[2]), .w_sop(w_sop[2]), .w_id(w_id[2]), .busy(busy[2]));

  fifo_packet_combiner #(.WIDTH(4), .DATA_W(32), .ENCODER_MODE("ROUND_ROBIN"),
    .PKT_MODE("TRUE"), .OUT_REG("TRUE")) u_rr_oreg (
    .clk(clk), .nrst(nrst), .r_empty(r_empty[3]), .r_req(r_req[3]), .r_data(r_data[3]),
    .r_last(r_last[3]), .w_full(w_full[3]), .w_req(w_req[3]), .w_data(w_data[3]),
    .w_last(w_last[3]), .w_sop(w_sop[3]), .w_id(w_id[3]), .busy(busy[3]));

  function automatic logic [35:0] ex(logic [1:0] id, logic sop, logic last, logic [31:0] d);
    return {id, sop, last, d};
  endfunction

  // Drive FWFT inputs from the heads of the source queues.
  task automatic refresh();
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (src_q[k][c].size() == 0 || hold[k][c]) begin
          r_empty[k][c]           = 1'b1;
          r_last[k][c]            = 1'b0;
          r_data[k][c*32 +: 32]   = 32'h0;
        end else begin
          r_empty[k][c]           = 1'b0;
          r_last[k][c]            = src_q[k][c][0][32];
          r_data[k][c*32 +: 32]   = src_q[k][c][0][31:0];
        end
      end
    end
  endtask

  task automatic put(int k, int c, logic last, logic [31:0] d);
    src_q[k][c].push_back({last, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drained(int k, int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q[k].size() == 0) break;
      tick();
    end
  endtask

  // Scoreboard consumer: every written word must match the next expected one.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      pop_mask[k] = r_req[k];
      if (w_req[k] === 1'b1) begin
        n_tests++;
        if (exp_q[k].size() == 0) begin
          n_fail++;
          $display("FAIL sb%0d unexpected word: got id=%0d sop=%b last=%b data=%h, want none",
                   k, w_id[k], w_sop[k], w_last[k], w_data[k]);
        end else begin
          sb_e = exp_q[k].pop_front();
          if ({w_id[k], w_sop[k], w_last[k], w_data[k]} !== sb_e) begin
            n_fail++;
            $display("FAIL sb%0d word: got id=%0d sop=%b last=%b data=%h, want id=%0d sop=%b last=%b data=%h",
                     k, w_id[k], w_sop[k], w_last[k], w_data[k],
                     sb_e[35:34], sb_e[33], sb_e[32], sb_e[31:0]);
          end
        end
      end
    end
  end

  // Source FIFOs advance on every read strobe seen in the previous cycle.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NI; k++)
      for (int c = 0; c < 4; c++)
        if (pop_mask[k][c] === 1'b1 && src_q[k][c].size() > 0)
          void'(src_q[k][c].pop_front());
    refresh();
  end

  task automatic test_reset();
    nrst = 1'b0;
    refresh();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if ({r_req[k], w_req[k], w_data[k], w_last[k], w_sop[k], w_id[k], busy[k]} !== 42'h0) begin
        n_fail++;
        $display("FAIL reset%0d: got r_req=%b w_req=%b w_data=%h sop=%b last=%b id=%0d busy=%b, want all 0",
                 k, r_req[k], w_req[k], w_data[k], w_sop[k], w_last[k], w_id[k], busy[k]);
      end
    end
    @(posedge clk);
    #2;
    nrst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (w_req[k] !== 1'b0 || r_req[k] !== 4'b0) begin
        n_fail++;
        $display("FAIL idle%0d: got w_req=%b r_req=%b, want 0 0000", k, w_req[k], r_req[k]);
      end
    end
    tick();
  endtask

  task automatic test_packet();
    logic       e_busy [4];
    logic [3:0] e_rreq [4];
    e_busy = '{1'b1, 1'b1, 1'b0, 1'b0};
    e_rreq = '{4'b0001, 4'b0001, 4'b0001, 4'b0100};
    put(0, 0, 1'b0, 32'hA000_0000); put(0, 0, 1'b0, 32'hA000_0001); put(0, 0, 1'b1, 32'hA000_0002);
    put(0, 2, 1'b1, 32'hB000_0000);
    exp_q[0].push_back(ex(2'd0, 1'b1, 1'b0, 32'hA000_0000));
    exp_q[0].push_back(ex(2'd0, 1'b0, 1'b0, 32'hA000_0001));
    exp_q[0].push_back(ex(2'd0, 1'b0, 1'b1, 32'hA000_0002));
    exp_q[0].push_back(ex(2'd2, 1'b1, 1'b1, 32'hB000_0000));
    refresh();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (w_req[0] !== 1'b1 || busy[0] !== e_busy[i] || r_req[0] !== e_rreq[i]) begin
        n_fail++;
        $display("FAIL packet cycle %0d: got w_req=%b busy=%b r_req=%b, want 1 %b %b",
                 i, w_req[0], busy[0], r_req[0], e_busy[i], e_rreq[i]);
      end
      tick();
    end
    @(negedge clk);
    n_tests++;
    if (w_req[0] !== 1'b0 || busy[0] !== 1'b0 || exp_q[0].size() != 0) begin
      n_fail++;
      $display("FAIL packet end: got w_req=%b busy=%b pending=%0d, want 0 0 0",
               w_req[0], busy[0], exp_q[0].size());
    end
    tick();
  endtask

  task automatic test_gap();
    logic       e_wreq [7];
    logic       e_busy [7];
    logic [3:0] e_rreq [7];
    e_wreq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    e_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    e_rreq = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100};
    put(0, 0, 1'b0, 32'hA100_0000); put(0, 0, 1'b0, 32'hA100_0001); put(0, 0, 1'b1, 32'hA100_0002);
    put(0, 2, 1'b1, 32'hB100_0000);
    exp_q[0].push_back(ex(2'd0, 1'b1, 1'b0, 32'hA100_0000));
    exp_q[0].push_back(ex(2'd0, 1'b0, 1'b0, 32'hA100_0001));
    exp_q[0].push_back(ex(2'd0, 1'b0, 1'b1, 32'hA100_0002));
    exp_q[0].push_back(ex(2'd2, 1'b1, 1'b1, 32'hB100_0000));
    refresh();
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin hold[0][0] = 1'b1; refresh(); end
      if (i == 5) begin hold[0][0] = 1'b0; refresh(); end
      @(negedge clk);
      n_tests++;
      if (w_req[0] !== e_wreq[i] || busy[0] !== e_busy[i] || r_req[0] !== e_rreq[i]) begin
        n_fail++;
        $display("FAIL gap cycle %0d: got w_req=%b busy=%b r_req=%b, want %b %b %b",
                 i, w_req[0], busy[0], r_req[0], e_wreq[i], e_busy[i], e_rreq[i]);
      end
      tick();
    end
    n_tests++;
    if (exp_q[0].size() != 0) begin
      n_fail++;
      $display("FAIL gap drain: got %0d pending, want 0", exp_q[0].size());
    end
  endtask

  task automatic test_reset_mid();
    logic       e_wreq [6];
    logic       e_busy [6];
    logic [3:0] e_rreq [6];
    e_wreq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    e_busy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    e_rreq = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
    for (int j = 0; j < 4; j++) put(0, 0, (j == 3), 32'hA200_0000 + j);
    put(0, 1, 1'b1, 32'hC200_0000);
    exp_q[0].push_back(ex(2'd0, 1'b1, 1'b0, 32'hA200_0000));
    exp_q[0].push_back(ex(2'd0, 1'b0, 1'b0, 32'hA200_0001));
    exp_q[0].push_back(ex(2'd0, 1'b1, 1'b0, 32'hA200_0002));
    exp_q[0].push_back(ex(2'd0, 1'b0, 1'b1, 32'hA200_0003));
    exp_q[0].push_back(ex(2'd1, 1'b1, 1'b1, 32'hC200_0000));
    refresh();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) nrst = 1'b0;
      if (i == 3) nrst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (w_req[0] !== e_wreq[i] || busy[0] !== e_busy[i] || r_req[0] !== e_rreq[i]) begin
        n_fail++;
        $display("FAIL rstmid cycle %0d: got w_req=%b busy=%b r_req=%b, want %b %b %b",
                 i, w_req[0], busy[0], r_req[0], e_wreq[i], e_busy[i], e_rreq[i]);
      end
      if (i == 2) begin
        n_tests++;
        if ({w_data[0], w_sop[0], w_last[0], w_id[0]} !== 36'h0) begin
          n_fail++;
          $display("FAIL rstmid outputs: got data=%h sop=%b last=%b id=%0d, want 0",
                   w_data[0], w_sop[0], w_last[0], w_id[0]);
        end
      end
      tick();
    end
    n_tests++;
    if (exp_q[0].size() != 0) begin
      n_fail++;
      $display("FAIL rstmid drain: got %0d pending, want 0", exp_q[0].size());
    end
  endtask

  task automatic test_priority();
    for (int j = 0; j < 6; j++) begin
      put(1, 1, (j == 2), 32'h1100_0000 + j);
      exp_q[1].push_back(ex(2'd1, 1'b1, (j == 2), 32'h1100_0000 + j));
    end
    for (int j = 0; j < 6; j++) put(1, 3, (j == 5), 32'h1300_0000 + j);
    for (int j = 0; j < 6; j++) exp_q[1].push_back(ex(2'd3, 1'b1, (j == 5), 32'h1300_0000 + j));
    refresh();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (r_req[1] !== 4'b0010 || w_id[1] !== 2'd1 || w_sop[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL prio cycle %0d: got r_req=%b id=%0d sop=%b, want 0010 1 1",
                 i, r_req[1], w_id[1], w_sop[1]);
      end
      tick();
    end
    n_tests++;
    if (src_q[1][3].size() != 6) begin
      n_fail++;
      $display("FAIL prio starve: got ch3 depth %0d, want 6", src_q[1][3].size());
    end
    wait_drained(1, 20);
    n_tests++;
    if (exp_q[1].size() != 0) begin
      n_fail++;
      $display("FAIL prio drain: got %0d pending, want 0", exp_q[1].size());
    end
  endtask

  task automatic test_rr_full();
    int n_pop;
    n_pop = 0;
    for (int j = 0; j < 3; j++)
      for (int c = 0; c < 4; c++) begin
        put(2, c, (j == 1), 32'h2000_0000 + (c << 8) + j);
        exp_q[2].push_back(ex(c[1:0], 1'b1, (j == 1), 32'h2000_0000 + (c << 8) + j));
      end
    refresh();
    for (int i = 0; i < 14; i++) begin
      if (i == 5) w_full[2] = 1'b1;
      if (i == 7) w_full[2] = 1'b0;
      @(negedge clk);
      n_tests++;
      if (i == 5 || i == 6) begin
        if (w_req[2] !== 1'b0 || r_req[2] !== 4'b0) begin
          n_fail++;
          $display("FAIL rr full cycle %0d: got w_req=%b r_req=%b, want 0 0000", i, w_req[2], r_req[2]);
        end
      end else begin
        if (w_req[2] !== 1'b1 || w_id[2] !== 2'(n_pop % 4)) begin
          n_fail++;
          $display("FAIL rr cycle %0d: got w_req=%b id=%0d, want 1 %0d", i, w_req[2], w_id[2], n_pop % 4);
        end
        n_pop++;
      end
      tick();
    end
    n_tests++;
    if (exp_q[2].size() != 0) begin
      n_fail++;
      $display("FAIL rr drain: got %0d pending, want 0", exp_q[2].size());
    end
  endtask

  task automatic test_out_reg();
    logic        prev_req;
    logic [31:0] prev_data;
    prev_req  = 1'b0;
    prev_data = 32'h0;
    put(3, 1, 1'b0, 32'hD000_0000); put(3, 1, 1'b1, 32'hD000_0001);
    put(3, 3, 1'b1, 32'hE000_0000);
    exp_q[3].push_back(ex(2'd1, 1'b1, 1'b0, 32'hD000_0000));
    exp_q[3].push_back(ex(2'd1, 1'b0, 1'b1, 32'hD000_0001));
    exp_q[3].push_back(ex(2'd3, 1'b1, 1'b1, 32'hE000_0000));
    refresh();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (w_req[3] !== prev_req) begin
        n_fail++;
        $display("FAIL oreg latency cycle %0d: got w_req=%b, want %b", i, w_req[3], prev_req);
      end
      n_tests++;
      if (w_req[3] === 1'b1 && w_data[3] !== prev_data) begin
        n_fail++;
        $display("FAIL oreg data cycle %0d: got %h, want %h", i, w_data[3], prev_data);
      end else if (w_req[3] !== 1'b1 && {w_data[3], w_last[3], w_sop[3], w_id[3]} !== 36'h0) begin
        n_fail++;
        $display("FAIL oreg idle cycle %0d: got data=%h last=%b sop=%b id=%0d, want 0",
                 i, w_data[3], w_last[3], w_sop[3], w_id[3]);
      end
      prev_req = |r_req[3];
      for (int c = 0; c < 4; c++)
        if (r_req[3][c] === 1'b1) prev_data = r_data[3][c*32 +: 32];
      tick();
    end
    n_tests++;
    if (exp_q[3].size() != 0) begin
      n_fail++;
      $display("FAIL oreg drain: got %0d pending, want 0", exp_q[3].size());
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      hold[k]     = 4'b0;
      w_full[k]   = 1'b0;
      pop_mask[k] = 4'b0;
    end
    nrst = 1'b0;
    refresh();
    test_reset();
    test_packet();
    test_gap();
    test_reset_mid();
    test_priority();
    test_rr_full();
    test_out_reg();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
